// File: rtl/ballot_session_ctrl.sv
// ballot_session_ctrl
// Per-voter ballot sequencer. Debounces the candidate buttons and arms one ballot
// per officer enable. Resolves simultaneous presses, then issues exactly one
// one-hot commit strobe per voter session, followed by an acknowledge lockout.
module ballot_session_ctrl #(
  parameter int NUM_CAND        = 4,
  parameter int DEBOUNCE_CYCLES = 10,
  parameter int TIMEOUT_CYCLES  = 1000,
  parameter int LOCKOUT_CYCLES  = 10,
  parameter int CNT_W           = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                mode,
  input  logic                ballot_enable,
  input  logic [NUM_CAND-1:0] btn,
  output logic [NUM_CAND-1:0] commit_strobe,
  output logic                ack_led,
  output logic                spoiled,
  output logic                timeout,
  output logic                armed,
  output logic [CNT_W-1:0]    voter_count
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LK_W = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_FIRE = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LK_W-1:0] LK_LAST = LK_W'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    COMMIT  = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  state_t              state_r;
  logic [DB_W-1:0]     db_cnt_r [NUM_CAND];
  logic [NUM_CAND-1:0] ev_r;
  logic [TO_W-1:0]     timer_r;
  logic [LK_W-1:0]     lock_r;
  logic                ev_any_s;
  logic                ev_multi_s;

  // Per-button debounce: count consecutive high samples, pulse once on reaching the threshold.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CAND; i++) begin
        db_cnt_r[i] <= '0;
      end
      ev_r <= '0;
    end else begin
      for (int i = 0; i < NUM_CAND; i++) begin
        if (btn[i]) begin
          if (db_cnt_r[i] != DB_MAX) begin
            db_cnt_r[i] <= db_cnt_r[i] + DB_W'(1);
          end
          // Fires only on the transition into the saturated count, so a held button yields one event.
          ev_r[i] <= (db_cnt_r[i] == DB_FIRE);
        end else begin
          db_cnt_r[i] <= '0;
          ev_r[i]     <= 1'b0;
        end
      end
    end
  end

  // Classify this cycle's recognised presses: any, and more than one (clearing the lowest set bit leaves something).
  always_comb begin
    ev_any_s   = |ev_r;
    ev_multi_s = |(ev_r & (ev_r - NUM_CAND'(1)));
  end

  // Session FSM with registered outputs; the strobe register doubles as the latched candidate.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= IDLE;
      timer_r       <= '0;
      lock_r        <= '0;
      commit_strobe <= '0;
      ack_led       <= 1'b0;
      spoiled       <= 1'b0;
      timeout       <= 1'b0;
      armed         <= 1'b0;
      voter_count   <= '0;
    end else begin
      commit_strobe <= '0;
      spoiled       <= 1'b0;
      timeout       <= 1'b0;
      case (state_r)
        IDLE: begin
          if (ballot_enable && !mode) begin
            state_r <= ARMED;
            armed   <= 1'b1;
            timer_r <= '0;
          end
        end
        ARMED: begin
          if (mode) begin
            // Result mode aborts the ballot before any event is considered.
            state_r <= IDLE;
            armed   <= 1'b0;
          end else if (ev_any_s && !ev_multi_s) begin
            state_r       <= COMMIT;
            armed         <= 1'b0;
            commit_strobe <= ev_r;
            if (!(&voter_count)) begin
              voter_count <= voter_count + CNT_W'(1);
            end
          end else if (ev_multi_s) begin
            spoiled <= 1'b1;
            timer_r <= '0;
          end else if (timer_r == TO_LAST) begin
            state_r <= IDLE;
            armed   <= 1'b0;
            timeout <= 1'b1;
          end else begin
            timer_r <= timer_r + TO_W'(1);
          end
        end
        COMMIT: begin
          state_r <= LOCKOUT;
          ack_led <= 1'b1;
          lock_r  <= '0;
        end
        LOCKOUT: begin
          if (lock_r == LK_LAST) begin
            state_r <= IDLE;
            ack_led <= 1'b0;
          end else begin
            lock_r <= lock_r + LK_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          armed   <= 1'b0;
          ack_led <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ballot_session_ctrl.sv
// Self-checking bench for ballot_session_ctrl: directed scenarios followed by
// random stimulus, all compared every cycle against an event-level reference model.
module tb_ballot_session_ctrl;

  localparam int D = 10;
  localparam int T = 1000;
  localparam int L = 10;

  localparam int P_IDLE   = 0;
  localparam int P_ARMED  = 1;
  localparam int P_COMMIT = 2;
  localparam int P_LOCK   = 3;

  logic       clock;
  logic       reset;
  logic       mode;
  logic       ballot_enable;
  logic [3:0] btn;

  logic [3:0]  commit_strobe;
  logic        ack_led;
  logic        spoiled;
  logic        timeout;
  logic        armed;
  logic [15:0] voter_count;

  logic [3:0]  s_commit_strobe;
  logic        s_ack_led;
  logic        s_spoiled;
  logic        s_timeout;
  logic        s_armed;
  logic [1:0]  s_voter_count;

  int n_cmp;
  int n_bad;

  // reference model state
  int   m_phase;
  int   m_edge;
  int   m_deadline;
  int   m_lock_end;
  int   m_run [4];
  bit [3:0] m_ev;
  bit [3:0] e_strobe;
  bit   e_spoil;
  bit   e_tout;
  int   e_cnt_w;
  int   e_cnt_n;

  logic [3:0] rb;
  bit         rbe;
  bit         rmd;
  bit         rrs;

  ballot_session_ctrl #(
    .NUM_CAND(4), .DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T), .LOCKOUT_CYCLES(L), .CNT_W(16)
  ) u_dut (
    .clock(clock), .reset(reset), .mode(mode), .ballot_enable(ballot_enable), .btn(btn),
    .commit_strobe(commit_strobe), .ack_led(ack_led), .spoiled(spoiled),
    .timeout(timeout), .armed(armed), .voter_count(voter_count)
  );

  ballot_session_ctrl #(
    .NUM_CAND(4), .DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T), .LOCKOUT_CYCLES(L), .CNT_W(2)
  ) u_sat (
    .clock(clock), .reset(reset), .mode(mode), .ballot_enable(ballot_enable), .btn(btn),
    .commit_strobe(s_commit_strobe), .ack_led(s_ack_led), .spoiled(s_spoiled),
    .timeout(s_timeout), .armed(s_armed), .voter_count(s_voter_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model across one rising edge, given the inputs presented for it.
  task automatic model_step(input bit md, input bit be, input logic [3:0] b, input bit rs);
    int nev;
    m_edge++;
    e_strobe = 4'd0;
    e_spoil  = 1'b0;
    e_tout   = 1'b0;
    if (rs) begin
      m_phase = P_IDLE;
      e_cnt_w = 0;
      e_cnt_n = 0;
      m_ev    = 4'd0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      return;
    end
    nev = $countones(m_ev);
    case (m_phase)
      P_IDLE: begin
        if (be && !md) begin
          m_phase    = P_ARMED;
          m_deadline = m_edge + T;
        end
      end
      P_ARMED: begin
        if (md) begin
          m_phase = P_IDLE;
        end else if (nev == 1) begin
          e_strobe = m_ev;
          m_phase  = P_COMMIT;
          e_cnt_w  = (e_cnt_w + 1 > 65535) ? 65535 : e_cnt_w + 1;
          e_cnt_n  = (e_cnt_n + 1 > 3) ? 3 : e_cnt_n + 1;
        end else if (nev >= 2) begin
          e_spoil    = 1'b1;
          m_deadline = m_edge + T;
        end else if (m_edge == m_deadline) begin
          e_tout  = 1'b1;
          m_phase = P_IDLE;
        end
      end
      P_COMMIT: begin
        m_phase    = P_LOCK;
        m_lock_end = m_edge + L;
      end
      default: begin
        if (m_edge == m_lock_end) m_phase = P_IDLE;
      end
    endcase
    // a press is recognised once its run of high samples reaches exactly D
    for (int i = 0; i < 4; i++) begin
      m_run[i] = b[i] ? m_run[i] + 1 : 0;
      m_ev[i]  = (m_run[i] == D);
    end
  endtask

  task automatic do_cycle(input bit md, input bit be, input logic [3:0] b, input bit rs);
    mode          = md;
    ballot_enable = be;
    btn           = b;
    reset         = rs;
    model_step(md, be, b, rs);
    @(negedge clock);
    check_eq("strobe",    32'(commit_strobe),   32'(e_strobe));
    check_eq("ack_led",   32'(ack_led),         32'(m_phase == P_LOCK));
    check_eq("spoiled",   32'(spoiled),         32'(e_spoil));
    check_eq("timeout",   32'(timeout),         32'(e_tout));
    check_eq("armed",     32'(armed),           32'(m_phase == P_ARMED));
    check_eq("count",     32'(voter_count),     32'(e_cnt_w));
    check_eq("sat_count", 32'(s_voter_count),   32'(e_cnt_n));
    check_eq("sat_strobe", 32'(s_commit_strobe), 32'(e_strobe));
  endtask

  task automatic run_n(input int cnt, input bit md, input logic [3:0] b);
    repeat (cnt) do_cycle(md, 1'b0, b, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    m_phase = P_IDLE;
    m_edge = 0;
    m_deadline = 0;
    m_lock_end = 0;
    m_ev = 4'd0;
    e_cnt_w = 0;
    e_cnt_n = 0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
    rb = 4'd0;

    // reset state
    repeat (3) do_cycle(1'b0, 1'b0, 4'd0, 1'b1);
    check_eq("reset_count", 32'(voter_count), 32'd0);
    check_eq("reset_armed", 32'(armed), 32'd0);

    // single clean ballot
    do_cycle(1'b0, 1'b1, 4'd0, 1'b0);
    run_n(12, 1'b0, 4'b0100);
    run_n(15, 1'b0, 4'd0);
    check_eq("first_ballot_count", 32'(voter_count), 32'd1);

    // simultaneous press spoils, then a single press commits
    do_cycle(1'b0, 1'b1, 4'd0, 1'b0);
    run_n(2, 1'b0, 4'd0);
    run_n(12, 1'b0, 4'b0011);
    run_n(2, 1'b0, 4'd0);
    check_eq("armed_after_spoil", 32'(armed), 32'd1);
    run_n(12, 1'b0, 4'b0001);
    run_n(15, 1'b0, 4'd0);
    check_eq("after_spoil_count", 32'(voter_count), 32'd2);

    // armed ballot expires
    do_cycle(1'b0, 1'b1, 4'd0, 1'b0);
    run_n(1002, 1'b0, 4'd0);
    check_eq("timeout_count", 32'(voter_count), 32'd2);
    check_eq("timeout_idle", 32'(armed), 32'd0);

    // button held since IDLE does not vote; release and re-press does; enable in lockout ignored
    run_n(12, 1'b0, 4'b1000);
    do_cycle(1'b0, 1'b1, 4'b1000, 1'b0);
    run_n(20, 1'b0, 4'b1000);
    check_eq("held_no_commit", 32'(voter_count), 32'd2);
    check_eq("held_still_armed", 32'(armed), 32'd1);
    run_n(1, 1'b0, 4'd0);
    run_n(12, 1'b0, 4'b1000);
    do_cycle(1'b0, 1'b1, 4'd0, 1'b0);
    run_n(15, 1'b0, 4'd0);
    check_eq("lockout_enable_ignored", 32'(armed), 32'd0);
    check_eq("repress_count", 32'(voter_count), 32'd3);

    // result mode aborts and blocks arming
    do_cycle(1'b0, 1'b1, 4'd0, 1'b0);
    do_cycle(1'b1, 1'b0, 4'd0, 1'b0);
    check_eq("mode_abort", 32'(armed), 32'd0);
    do_cycle(1'b1, 1'b1, 4'd0, 1'b0);
    run_n(3, 1'b1, 4'd0);
    check_eq("mode_blocks_enable", 32'(armed), 32'd0);
    run_n(2, 1'b0, 4'd0);

    // reset during lockout and during debounce
    do_cycle(1'b0, 1'b1, 4'd0, 1'b0);
    run_n(12, 1'b0, 4'b0010);
    run_n(2, 1'b0, 4'd0);
    do_cycle(1'b0, 1'b0, 4'd0, 1'b1);
    check_eq("rst_lock_ack", 32'(ack_led), 32'd0);
    check_eq("rst_lock_count", 32'(voter_count), 32'd0);
    do_cycle(1'b0, 1'b1, 4'd0, 1'b0);
    run_n(5, 1'b0, 4'b0100);
    do_cycle(1'b0, 1'b0, 4'b0100, 1'b1);
    check_eq("rst_armed", 32'(armed), 32'd0);
    run_n(12, 1'b0, 4'd0);
    check_eq("rst_no_commit", 32'(voter_count), 32'd0);

    // five ballots: saturation of the narrow counter
    repeat (5) begin
      do_cycle(1'b0, 1'b1, 4'd0, 1'b0);
      run_n(12, 1'b0, 4'b0001);
      run_n(12, 1'b0, 4'd0);
    end
    check_eq("five_wide", 32'(voter_count), 32'd5);
    check_eq("five_sat", 32'(s_voter_count), 32'd3);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0:       rb = 4'd0;
          1:       rb = 4'b0001 << $urandom_range(0, 3);
          2:       rb = 4'($urandom_range(0, 15));
          default: rb = 4'd0;
        endcase
      end
      rbe = ($urandom_range(0, 19) == 0);
      rmd = ($urandom_range(0, 39) == 0);
      rrs = ($urandom_range(0, 599) == 0);
      do_cycle(rmd, rbe, rb, rrs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
